// File: rtl/mcse_bus_translator.sv
// mcse_bus_translator: MCSE single-request bus to 32-bit AHB-Lite master.
// Optional window/alignment check enabled by MCSE_BUS_ADDR_CHECK_EN.
module mcse_bus_translator #(
    parameter int unsigned pAHB_ADDR_WIDTH    = 32,
    parameter int unsigned pAHB_DATA_WIDTH    = 32,
    parameter int unsigned pPAYLOAD_SIZE_BITS = 128,
    parameter logic [31:0] pWINDOW_BASE       = 32'h0000_0000,
    parameter logic [31:0] pWINDOW_SIZE       = 32'h0001_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bootControl_bus_go,
    input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
    input  logic                          bootControl_bus_RW,
    output logic                          bootControl_bus_done,
    output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
    output logic                          bootControl_bus_err,
    output logic [pAHB_ADDR_WIDTH-1:0]    HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [pAHB_DATA_WIDTH-1:0]    HWDATA,
    input  logic [pAHB_DATA_WIDTH-1:0]    HRDATA,
    input  logic                          HREADY,
    input  logic                          HRESP
);

    localparam int unsigned AW = pAHB_ADDR_WIDTH;
    localparam int unsigned DW = pAHB_DATA_WIDTH;
    localparam int unsigned PW = pPAYLOAD_SIZE_BITS;
    localparam int unsigned N  = PW / DW;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] LAST       = IW'(N - 1);
    localparam logic [AW-1:0] BEAT_BYTES = AW'(DW / 8);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_ERR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0] payload_q;
    logic [PW-1:0] rd_data_q;
    logic          err_q;
    logic [AW-1:0] haddr_q;
    logic [1:0]    htrans_q;
    logic          hwrite_q;
    logic [DW-1:0] hwdata_q;
    logic [IW-1:0] a_idx_q;
    logic [IW-1:0] d_idx_q;
    logic          d_vld_q;

    logic a_act;
    logic xfer_end;
    logic reject;

    assign a_act    = (htrans_q == T_NONSEQ);
    assign xfer_end = HREADY && !HRESP && d_vld_q && (d_idx_q == LAST);

`ifdef MCSE_BUS_ADDR_CHECK_EN
    // 64-bit compare so window end and request end cannot wrap
    logic [63:0] req_lo;
    logic [63:0] req_hi;
    logic [63:0] win_lo;
    logic [63:0] win_hi;

    assign req_lo = 64'(bootControl_bus_addr);
    assign req_hi = req_lo + 64'(N) * 64'(DW / 8);
    assign win_lo = 64'(pWINDOW_BASE);
    assign win_hi = win_lo + 64'(pWINDOW_SIZE);
    assign reject = (bootControl_bus_addr[1:0] != 2'b00)
                 || (req_lo < win_lo)
                 || (req_hi > win_hi);
`else
    logic unused_win;

    assign unused_win = ^{pWINDOW_BASE, pWINDOW_SIZE};
    assign reject     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bootControl_bus_go) begin
                    state_d = reject ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (HRESP) begin
                    state_d = HREADY ? S_DONE : S_ERR;
                end else if (xfer_end) begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bootControl_bus_done = 1'b0;
        unique case (state_q)
            S_DONE:  bootControl_bus_done = 1'b1;
            default: bootControl_bus_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            haddr_q   <= '0;
            htrans_q  <= T_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            a_idx_q   <= '0;
            d_idx_q   <= '0;
            d_vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bootControl_bus_go) begin
                        payload_q <= bootControl_bus_write;
                        err_q     <= 1'b0;
                        if (reject) begin
                            err_q     <= 1'b1;
                            rd_data_q <= '0;
                        end else begin
                            htrans_q <= T_NONSEQ;
                            haddr_q  <= bootControl_bus_addr;
                            hwrite_q <= bootControl_bus_RW;
                            a_idx_q  <= '0;
                            d_vld_q  <= 1'b0;
                        end
                    end
                end
                S_XFER: begin
                    if (HRESP) begin
                        // first error cycle: cancel whatever is pending
                        htrans_q <= T_IDLE;
                        if (HREADY) begin
                            err_q     <= 1'b1;
                            rd_data_q <= '0;
                            d_vld_q   <= 1'b0;
                        end
                    end else if (HREADY) begin
                        if (d_vld_q && !hwrite_q) begin
                            rd_data_q[d_idx_q*DW +: DW] <= HRDATA;
                        end
                        d_vld_q <= a_act;
                        if (a_act) begin
                            d_idx_q  <= a_idx_q;
                            hwdata_q <= payload_q[a_idx_q*DW +: DW];
                            if (a_idx_q == LAST) begin
                                htrans_q <= T_IDLE;
                            end else begin
                                a_idx_q <= a_idx_q + IW'(1);
                                haddr_q <= haddr_q + BEAT_BYTES;
                            end
                        end
                    end
                end
                S_ERR: begin
                    if (HREADY) begin
                        err_q     <= 1'b1;
                        rd_data_q <= '0;
                        d_vld_q   <= 1'b0;
                    end
                end
                default: begin
                    d_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bootControl_bus_rdData = rd_data_q;
    assign bootControl_bus_err    = err_q;
    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

endmodule

// File: doc/mcse_bus_translator.md
# mcse_bus_translator

Converts the MCSE control unit's single-request bus interface (go / addr / payload / RW → done / rdData) into a sequence of 32-bit AHB-Lite master transfers. Sits directly downstream of the control unit's secure-boot / firmware-authentication bus multiplexer, in front of the SoC AHB fabric. Each request moves one full payload, such as an IP-ID record or a firmware block. The payload is split into little-endian beats issued as back-to-back pipelined SINGLE transfers.

## Interface
- pAHB_ADDR_WIDTH, 32, AHB address width
- pAHB_DATA_WIDTH, 32, AHB data width; fixed 32 (HSIZE word)
- pPAYLOAD_SIZE_BITS, 128, payload width; must be a multiple of pAHB_DATA_WIDTH; N = pPAYLOAD_SIZE_BITS/32 beats
- pWINDOW_BASE, 32'h0000_0000, permitted window base (only used with MCSE_BUS_ADDR_CHECK_EN)
- pWINDOW_SIZE, 32'h0001_0000, permitted window size in bytes (only used with MCSE_BUS_ADDR_CHECK_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- bootControl_bus_go  in  1  request; sampled only in IDLE
- bootControl_bus_addr  in  pAHB_ADDR_WIDTH  byte address of beat 0
- bootControl_bus_write  in  pPAYLOAD_SIZE_BITS  write payload
- bootControl_bus_RW  in  1  1 = write, 0 = read
- bootControl_bus_done  out  1  one-cycle completion pulse
- bootControl_bus_rdData  out  pPAYLOAD_SIZE_BITS  assembled read data
- bootControl_bus_err  out  1  error status of last request; valid with done
- HADDR  out  pAHB_ADDR_WIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3 (constant 3'b010); HBURST  out  3 (constant 3'b000 SINGLE); HWDATA  out  32
- HRDATA  in  32; HREADY  in  1; HRESP  in  1

## Operation
- FSM states: IDLE, XFER, ERR, DONE.
- IDLE: on go=1, latch addr, payload and RW, clear err, and go to XFER. All other inputs are ignored while not in IDLE.
- XFER, address phase beat k (k = 0..N-1):
  - HTRANS = NONSEQ, HADDR = addr + 4k, HWRITE = RW.
  - Address phase advances only when HREADY = 1.
  - After beat N-1 is accepted, HTRANS = IDLE.
- XFER, data phase beat k: occupies the cycle after its address phase is accepted.
  - Write: HWDATA = payload[32k+31:32k], held while HREADY = 0.
  - Read: on HREADY = 1, HRDATA is captured into rdData[32k+31:32k].
- XFER ends when data phase N-1 completes with HREADY = 1 and HRESP = 0. The FSM then goes to DONE.
- HRESP = 1 with HREADY = 0 (first error cycle):
  - next cycle drive HTRANS = IDLE (cancel pending beats);
  - go to ERR, wait for HREADY = 1 (second error cycle);
  - go to DONE with err = 1 and rdData cleared to 0.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
  - rdData and err hold until the next accepted go.
  - A go still high in the cycle after done starts a new request. Requesters drop go on done.
- Address arithmetic wraps modulo 2^pAHB_ADDR_WIDTH; there is no carry flag.

## Timing
- Reset values: HTRANS = 2'b00, HADDR = 0, HWRITE = 0, HWDATA = 0, done = 0, err = 0, rdData = 0, FSM = IDLE. HSIZE and HBURST are constant.
- Zero-wait latency, go sampled at cycle 0:
  - address phases in cycles 1..N;
  - data phases in cycles 2..N+1;
  - done in cycle N+2 (cycle 6 for N = 4).
- Each HREADY = 0 cycle adds one cycle of latency. All AHB outputs are registered.
- Asynchronous reset mid-transfer forces the reset values immediately. The partial transaction is abandoned with no done pulse.

## Configuration
- MCSE_BUS_ADDR_CHECK_EN:
  - Defined: at go, the request is rejected if addr[1:0] != 0 or if [addr, addr+4N) is not fully inside [pWINDOW_BASE, pWINDOW_BASE+pWINDOW_SIZE).
  - A rejected request goes IDLE→DONE with err = 1 and rdData = 0, has no AHB activity, and pulses done at cycle 1.
  - Undefined: no check; every request is issued to AHB.

## Test plan
- Write, N = 4, addr 32'h100, payload 128'h4444…_3333…_2222…_1111…, HREADY always 1 -> HADDR 0x100/0x104/0x108/0x10C on cycles 1-4, HWDATA 0x1111…, 0x2222… on cycles 2-5 in order, done at cycle 6, err = 0.
- Read, addr 32'h200, HRDATA returns A,B,C,D -> rdData = {D,C,B,A} at done, cycle 6.
- Write with HREADY low for 2 cycles during beat 1's data phase -> HADDR and HWDATA held stable, done at cycle 8.
- Read with HRESP error on beat 2 -> HTRANS IDLE the cycle after the first error cycle, beat 3 never issued, done with err = 1 and rdData = 0.
- rst_n asserted at cycle 3 of a write -> HTRANS = 0 immediately, no done pulse; a new go after reset completes normally.
- With MCSE_BUS_ADDR_CHECK_EN, addr 32'h0001_FFF8 (outside window) -> no HTRANS activity, done at cycle 1, err = 1.
